// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shared main-memory arbiter and 8-word block-fill sequencer
// D-side requests win over I-side; each grant runs one 8-word read fill or one single-word write.
module mem_arbiter #(
  parameter int WORDS_PER_BLK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        i_fill_we,
  output logic        d_fill_we,
  output logic        i_done,
  output logic        d_done,
  output logic [15:0] mem_addr,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_data_out,
  input  logic [15:0] mem_data_in,
  input  logic        mem_data_valid
);

  localparam logic [3:0] NWORDS    = 4'(WORDS_PER_BLK);
  localparam logic [3:0] LAST_WORD = 4'(WORDS_PER_BLK - 1);

  typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  issue_cnt, recv_cnt;
  logic [11:0] blk;
  logic [15:0] wr_addr, wr_data;

  // Word offset inside a block is irrelevant on the I side.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_addr[3:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      issue_cnt <= 4'd0;
      recv_cnt  <= 4'd0;
      blk       <= 12'd0;
      wr_addr   <= 16'd0;
      wr_data   <= 16'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          issue_cnt <= 4'd0;
          recv_cnt  <= 4'd0;
          if (d_req && d_we) begin
            wr_addr <= d_addr;
            wr_data <= d_wdata;
          end else if (d_req) begin
            blk <= d_addr[15:4];
          end else if (i_req) begin
            blk <= i_addr[15:4];
          end
        end
        I_FILL, D_FILL: begin
          if (issue_cnt < NWORDS) issue_cnt <= issue_cnt + 4'd1;
          if (mem_data_valid)     recv_cnt  <= recv_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_addr     = 16'd0;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_data_out = 16'd0;
    fill_data    = 16'd0;
    fill_word    = 3'd0;
    i_fill_we    = 1'b0;
    d_fill_we    = 1'b0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req && d_we) state_d = D_WRITE;
        else if (d_req)    state_d = D_FILL;
        else if (i_req)    state_d = I_FILL;
      end
      I_FILL, D_FILL: begin
        // Issue and return overlap: reads go out back to back while earlier words come home.
        if (issue_cnt < NWORDS) begin
          mem_enable = 1'b1;
          mem_addr   = {blk, issue_cnt[2:0], 1'b0};
        end
        if (mem_data_valid) begin
          fill_data = mem_data_in;
          fill_word = recv_cnt[2:0];
          i_fill_we = (state_q == I_FILL);
          d_fill_we = (state_q == D_FILL);
          if (recv_cnt == LAST_WORD) begin
            i_done  = (state_q == I_FILL);
            d_done  = (state_q == D_FILL);
            state_d = IDLE;
          end
        end
      end
      D_WRITE: begin
        mem_enable   = 1'b1;
        mem_wr       = 1'b1;
        mem_addr     = wr_addr;
        mem_data_out = wr_data;
        d_done       = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a 4-cycle pipelined memory model
module tb_mem_arbiter;

  typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
  typedef struct { bit side; int word; logic [15:0] data; bit last; } fill_t;
  typedef struct { int ready; logic [15:0] data; } pend_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_data_valid = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_data_in = '0;
  logic [15:0] fill_data, mem_addr, mem_data_out;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_done, d_done, mem_enable, mem_wr;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we), .i_done(i_done), .d_done(d_done),
    .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;
  fill_t exp_fill[$];
  logic [15:0] exp_rd[$];
  wr_t exp_wr[$];
  pend_t pend[$];
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] bus_mem [logic [15:0]];
  int rd_total = 0, rd_base = 0, stall_at = -1, last_ready = -100;
  int i_done_cnt = 0, d_done_cnt = 0, i_fill_cnt = 0, i_done_cyc = 0, d_done_cyc = 0;
  int i_base = 0, d_base = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void flag_fail(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event seen or missing contrary to the model", name);
  endfunction

  function automatic logic [15:0] dflt(logic [15:0] a);
    return 16'(a * 16'd40503) ^ 16'h3C5A;
  endfunction

  function automatic logic [15:0] ref_rd(logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [15:0] bus_rd(logic [15:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
  endfunction

  // Reference: a block fill reads the 8 even addresses of the block in order.
  function automatic void push_fill(bit side, logic [15:0] addr);
    logic [15:0] a;
    for (int k = 0; k < 8; k++) begin
      a = {addr[15:4], 3'(k), 1'b0};
      exp_rd.push_back(a);
      exp_fill.push_back('{side, k, ref_rd(a), k == 7});
    end
  endfunction

  fill_t f;
  wr_t   w;
  pend_t p;
  bit    exp_idone, exp_ddone;

  always @(negedge clk) begin
    exp_idone = 1'b0;
    exp_ddone = 1'b0;
    if (mem_enable && !mem_wr) begin
      if (exp_rd.size() == 0) flag_fail("unexpected_read");
      else chk("rd_addr", 64'(mem_addr), 64'(exp_rd.pop_front()));
      p.ready = cyc + 4 + (((rd_total - rd_base) == stall_at) ? 3 : 0);
      if (p.ready <= last_ready) p.ready = last_ready + 1;
      last_ready = p.ready;
      p.data = bus_rd(mem_addr);
      pend.push_back(p);
      rd_total++;
    end
    if (mem_enable && mem_wr) begin
      if (exp_wr.size() == 0) flag_fail("unexpected_write");
      else begin
        w = exp_wr.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(w.addr));
        chk("wr_data", 64'(mem_data_out), 64'(w.data));
        bus_mem[mem_addr] = mem_data_out;
        exp_ddone = 1'b1;
      end
    end
    if (i_fill_we || d_fill_we) begin
      if (i_fill_we && d_fill_we) flag_fail("both_fill_we");
      if (exp_fill.size() == 0) flag_fail("unexpected_fill");
      else begin
        f = exp_fill.pop_front();
        chk("fill_side", 64'(d_fill_we), 64'(f.side));
        chk("fill_word", 64'(fill_word), 64'(f.word));
        chk("fill_data", 64'(fill_data), 64'(f.data));
        if (f.last) begin
          if (f.side) exp_ddone = 1'b1;
          else exp_idone = 1'b1;
        end
      end
    end
    if (i_done || exp_idone) chk("i_done", 64'(i_done), 64'(exp_idone));
    if (d_done || exp_ddone) chk("d_done", 64'(d_done), 64'(exp_ddone));
    if (i_fill_we) i_fill_cnt++;
    if (i_done) begin i_done_cnt++; i_done_cyc = cyc; end
    if (d_done) begin d_done_cnt++; d_done_cyc = cyc; end
  end

  // One cycle: drop requests whose done has been seen and present any matured memory word.
  task automatic step();
    @(posedge clk);
    #1;
    if (i_done_cnt != i_base) i_req = 1'b0;
    if (d_done_cnt != d_base) d_req = 1'b0;
    mem_data_valid = 1'b0;
    mem_data_in    = 16'd0;
    if (pend.size() > 0 && pend[0].ready <= cyc) begin
      mem_data_valid = 1'b1;
      mem_data_in    = pend[0].data;
      void'(pend.pop_front());
    end
  endtask

  task automatic run_scn(input bit ien, input bit den, input bit dwe, input logic [15:0] ia,
                         input logic [15:0] da, input logic [15:0] dw, input int stall, input bit stray);
    int t, exp_d, exp_i, nd;
    bit sd, si, i_seen, d_seen;
    step();
    chk("idle_mem_enable", 64'(mem_enable), 64'd0);
    if (stray && pend.size() == 0) begin
      mem_data_valid = 1'b1;
      mem_data_in    = 16'($urandom);
    end
    step();
    nd = 0;
    if (den) begin
      if (dwe) begin
        exp_wr.push_back('{da, dw});
        ref_mem[da] = dw;
      end else begin
        push_fill(1'b1, da);
        nd = 8;
      end
    end
    if (ien) push_fill(1'b0, ia);
    rd_base  = rd_total;
    stall_at = stall;
    sd = den && !dwe && stall >= 0 && stall < 8;
    si = ien && stall >= nd && stall < nd + 8;
    i_base = i_done_cnt;
    d_base = d_done_cnt;
    t = cyc;
    i_req = ien; i_addr = ia; d_req = den; d_we = dwe; d_addr = da; d_wdata = dw;
    for (int k = 0; k < 100; k++) begin
      i_seen = (i_done_cnt != i_base);
      d_seen = (d_done_cnt != d_base);
      if ((!ien || i_seen) && (!den || d_seen)) break;
      step();
    end
    i_seen = (i_done_cnt != i_base);
    d_seen = (d_done_cnt != d_base);
    if (ien && !i_seen) flag_fail("i_done_timeout");
    if (den && !d_seen) flag_fail("d_done_timeout");
    exp_d = t + (dwe ? 1 : 12) + (sd ? 3 : 0);
    exp_i = (den ? exp_d + 1 : t) + 12 + (si ? 3 : 0);
    if (den && d_seen) chk("d_done_cycle", 64'(d_done_cyc - t), 64'(exp_d - t));
    if (ien && i_seen) chk("i_done_cycle", 64'(i_done_cyc - t), 64'(exp_i - t));
  endtask

  initial begin
    int nr, stall;
    bit ien, den, dwe;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({fill_data, fill_word, i_fill_we, d_fill_we, i_done, d_done,
                              mem_addr, mem_enable, mem_wr, mem_data_out}), 64'd0);
    rst = 1'b0;

    run_scn(1, 0, 0, 16'h1236, 16'h0000, 16'h0000, -1, 0);
    run_scn(0, 1, 1, 16'h0000, 16'h0404, 16'hBEEF, -1, 0);
    run_scn(1, 1, 0, 16'h1236, 16'h2000, 16'h0000, -1, 0);
    run_scn(1, 0, 0, 16'h0400, 16'h0000, 16'h0000, 5, 0);
    run_scn(1, 0, 0, 16'h7778, 16'h0000, 16'h0000, -1, 1);

    // Reset in the middle of an I fill, just after word 3 has been delivered.
    step();
    push_fill(1'b0, 16'h5550);
    rd_base = rd_total; stall_at = -1; i_base = i_done_cnt; i_fill_cnt = 0;
    i_req = 1'b1; i_addr = 16'h5550;
    for (int k = 0; k < 40; k++) begin
      if (i_fill_cnt >= 4) break;
      step();
    end
    if (i_fill_cnt < 4) flag_fail("reset_word3_timeout");
    step();
    rst = 1'b1;
    #1;
    chk("outputs_in_reset", 64'({fill_data, fill_word, i_fill_we, d_fill_we, i_done, d_done,
                                 mem_addr, mem_enable, mem_wr, mem_data_out}), 64'd0);
    i_req = 1'b0;
    exp_fill.delete();
    exp_rd.delete();
    step();
    step();
    rst = 1'b0;
    repeat (12) step();
    chk("late_valids_drained", 64'(pend.size()), 64'd0);
    run_scn(1, 0, 0, 16'h5550, 16'h0000, 16'h0000, -1, 0);

    for (int n = 0; n < 40; n++) begin
      ien = 1'($urandom_range(0, 1));
      den = 1'($urandom_range(0, 1));
      if (!ien && !den) ien = 1'b1;
      dwe = den && ($urandom_range(0, 1) == 1);
      nr = ((den && !dwe) ? 8 : 0) + (ien ? 8 : 0);
      stall = (nr > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, nr - 1)) : -1;
      run_scn(ien, den, dwe, 16'($urandom), 16'($urandom), 16'($urandom), stall,
              1'($urandom_range(0, 1)));
    end

    repeat (4) step();
    chk("scoreboard_empty", 64'(exp_fill.size() + exp_rd.size() + exp_wr.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port main-memory arbiter and block-fill sequencer that shares one multi-cycle pipelined memory between the instruction-cache miss path and the data-cache miss/write-through path. It sits between the two cache controllers and the unified main memory, replacing the two independent Memory instances used for instruction fetch and data access. Each cache raises a request. The arbiter grants one requester, sequences the 8-word block fill or the single-word write, streams the returned words back to the granted cache, and pulses done.

## Interface
- WORDS_PER_BLK, 8, words per cache block; fixed at 8, so the word index is 3 bits.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  I-cache fill request, level; held until i_done
- i_addr  in  16  I-side miss address; bits [3:0] ignored
- d_req  in  1  D-cache request, level; held until d_done
- d_we  in  1  D-side request is a single-word write-through (1) or a block fill (0)
- d_addr  in  16  D-side address; word address for writes, block address for fills
- d_wdata  in  16  D-side write data
- fill_data  out  16  returned memory word, shared by both sides
- fill_word  out  3  word index within block of fill_data
- i_fill_we  out  1  fill_data valid for the I-cache this cycle
- d_fill_we  out  1  fill_data valid for the D-cache this cycle
- i_done  out  1  one-cycle pulse: I fill complete
- d_done  out  1  one-cycle pulse: D fill or write complete
- mem_addr  out  16  memory address
- mem_enable  out  1  memory access this cycle
- mem_wr  out  1  write (1) / read (0) when enabled
- mem_data_out  out  16  write data to memory
- mem_data_in  in  16  read data from memory
- mem_data_valid  in  1  mem_data_in holds read data for the oldest outstanding read

## Operation
- FSM states: IDLE, I_FILL, D_FILL, D_WRITE. Reset state is IDLE.
- IDLE arbitration uses fixed priority:
  - d_req with d_we=1 goes to D_WRITE.
  - Else d_req goes to D_FILL.
  - Else i_req goes to I_FILL.
  - Else the FSM stays in IDLE.
- On grant, the block address {addr[15:4]} is captured into a register, or the full d_addr and d_wdata for writes. Request inputs are not re-sampled until the FSM returns to IDLE.
- Fill states (I_FILL, D_FILL):
  - issue_cnt (4 bits) starts at 0.
  - While issue_cnt < 8: mem_enable=1, mem_wr=0, mem_addr={blk[15:4], issue_cnt[2:0], 1'b0}, and issue_cnt increments.
  - recv_cnt (4 bits) starts at 0. Each mem_data_valid drives fill_data=mem_data_in and fill_word=recv_cnt[2:0], asserts the granted side's *_fill_we, and increments recv_cnt.
  - When mem_data_valid arrives with recv_cnt==7, the granted *_done pulses in that same cycle and the next state is IDLE.
- D_WRITE is one cycle: mem_enable=1, mem_wr=1, mem_addr=captured d_addr, mem_data_out=captured d_wdata, d_done=1. Next state is IDLE.
- The non-granted side never sees *_fill_we or *_done.
- mem_data_valid in IDLE or D_WRITE is ignored: no fill_we, no count change.
- Outputs are combinational from state, counters and mem_data_valid. When idle they are all 0: mem_*, fill_data, fill_word, *_fill_we, *_done.

## Timing
- Reset value of every output is 0. Reset asserted mid-transaction forces IDLE and clears counters and captured registers immediately (asynchronously). Words returned after reset are ignored.
- Grant latency: the request is sampled in IDLE at cycle T; the transaction state runs from T+1.
- Requesters hold their request until their own done. The FSM spends at least one IDLE cycle between transactions, so back-to-back grants are at T+1 and T+d+2, where d is the done cycle.
- A requester must deassert req by the IDLE cycle following its done (a Moore cache FSM satisfies this); a still-high req is a new request.
- Bench memory model: a read issued in cycle c returns mem_data_valid in cycle c+4, one word per cycle, in issue order.
- Fill timeline: reads are issued T+1..T+8, data returns T+5..T+12, done occurs at T+12, IDLE is at T+13, and the next grant is at T+14.
- Write timeline: the write occurs and d_done pulses at T+1, with IDLE at T+2.
- Simultaneous i_req and d_req: D is served first. I stays pending and is granted in the first IDLE cycle after d_done, provided d_req has dropped.
- Starvation of I under continuous D traffic is accepted; the pipeline stalls on a D miss.

## Test plan
- Reset: assert rst mid-I_FILL at word 3. Required: all outputs 0 in the same cycle. Late mem_data_valid pulses produce no fill_we. A later i_req refills from word 0.
- Lone I fill: i_req=1, i_addr=0x1236 at T. Required: mem_addr 0x1230,0x1232,…,0x123E at T+1..T+8. i_fill_we with fill_word 0..7 at T+5..T+12. i_done=1 only at T+12. d_fill_we stays 0.
- D write-through: d_req=1, d_we=1, d_addr=0x0404, d_wdata=0xBEEF. Required: mem_enable=mem_wr=1, mem_addr=0x0404, mem_data_out=0xBEEF, d_done at T+1, FSM idle at T+2.
- Contention: i_req and d_req (fill, 0x2000) rise together. Required: D fill completes first (d_done at T+12), I is granted at T+13, I reads start at T+14, and i_done comes at T+25.
- Stall-in-flight: memory model delays word 5's mem_data_valid by 3 cycles. Required: fill_word stays in sequence 0..7 and done tracks the 8th valid, not a fixed cycle.
- Stray mem_data_valid in IDLE: required no *_fill_we, counters unchanged, and the next fill still delivers exactly 8 words.
